// File: rtl/n64_reset_handler_pkg.sv
// n64_reset_handler_pkg: shared console lifecycle state type for the reset handler.
package sc64;
    typedef enum logic [2:0] {S_HARD, S_BOOT, S_ACTIVE, S_NMI, S_DRAIN} e_n64_reset_state;
endpackage

// File: rtl/n64_reset_handler_if.sv
// n64_reset_handler_if: console reset levels, drain handshake and CPU event reporting.
interface n64_reset_handler_if #(parameter int COUNT_WIDTH = 8);
    logic n64_hard_reset;
    logic n64_soft_reset;
    logic drain_ack;
    logic [1:0] flags_clear;
    logic drain_req;
    logic n64_active;
    logic soft_flag;
    logic hard_flag;
    logic irq;
    logic [COUNT_WIDTH-1:0] nmi_count;
    modport master (
        output n64_hard_reset, n64_soft_reset, drain_ack, flags_clear,
        input drain_req, n64_active, soft_flag, hard_flag, irq, nmi_count
    );
    modport slave (
        input n64_hard_reset, n64_soft_reset, drain_ack, flags_clear,
        output drain_req, n64_active, soft_flag, hard_flag, irq, nmi_count
    );
endinterface

// File: rtl/n64_reset_handler_filter.sv
// n64_reset_filter: flips its output only after the raw level has differed for FILTER_CYCLES edges.
module n64_reset_filter #(
    parameter int FILTER_CYCLES = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input logic clk,
    input logic reset,
    input logic raw,
    output logic filtered
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            filtered <= RESET_VALUE;
        end else if (raw == filtered) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            filtered <= raw;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/n64_reset_handler.sv
// n64_reset_handler: sequences console hard/soft reset into a filtered lifecycle with drain handshake and event flags.
module n64_reset_handler
    import sc64::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int RELEASE_DELAY = 1024,
    parameter int COUNT_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    n64_reset_handler_if.slave bus
);
    localparam int DW = $clog2(RELEASE_DELAY + 1);
    logic hard_f, soft_f, soft_set, hard_set;
    logic drain_req, n64_active, soft_flag, hard_flag, irq;
    logic [COUNT_WIDTH-1:0] nmi_count;
    logic [DW-1:0] delay;
    e_n64_reset_state state, state_n;
    n64_reset_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(1'b1)) u_hard (
        .clk(clk), .reset(reset), .raw(bus.n64_hard_reset), .filtered(hard_f)
    );
    n64_reset_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(1'b0)) u_soft (
        .clk(clk), .reset(reset), .raw(bus.n64_soft_reset), .filtered(soft_f)
    );
    // Hard reset always outranks a coincident NMI, so only one event can fire per cycle.
    always_comb begin
        state_n = state;
        soft_set = 1'b0;
        hard_set = 1'b0;
        case (state)
            S_HARD: state_n = hard_f ? S_HARD : S_BOOT;
            S_BOOT: state_n = hard_f ? S_HARD : (delay == '0) ? S_ACTIVE : S_BOOT;
            S_ACTIVE: begin
                state_n = hard_f ? S_DRAIN : soft_f ? S_NMI : S_ACTIVE;
                soft_set = !hard_f && soft_f;
            end
            S_NMI: state_n = hard_f ? S_DRAIN : soft_f ? S_NMI : S_ACTIVE;
            S_DRAIN: begin
                state_n = bus.drain_ack ? S_HARD : S_DRAIN;
                hard_set = bus.drain_ack;
            end
            default: state_n = S_HARD;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HARD;
            delay <= '0;
            drain_req <= 1'b0;
            n64_active <= 1'b0;
            soft_flag <= 1'b0;
            hard_flag <= 1'b0;
            irq <= 1'b0;
            nmi_count <= '0;
        end else begin
            state <= state_n;
            delay <= (state == S_HARD) ? DW'(RELEASE_DELAY - 1) : delay - DW'(state == S_BOOT && delay != '0);
            drain_req <= state_n == S_DRAIN;
            n64_active <= state_n == S_ACTIVE || state_n == S_NMI;
            soft_flag <= soft_set | (soft_flag & ~bus.flags_clear[0]);
            hard_flag <= hard_set | (hard_flag & ~bus.flags_clear[1]);
            irq <= soft_set | hard_set;
            nmi_count <= nmi_count + COUNT_WIDTH'(soft_set);
        end
    end
    assign bus.drain_req = drain_req;
    assign bus.n64_active = n64_active;
    assign bus.soft_flag = soft_flag;
    assign bus.hard_flag = hard_flag;
    assign bus.irq = irq;
    assign bus.nmi_count = nmi_count;
endmodule

// File: tb/tb_n64_reset_handler.sv
// tb_n64_reset_handler: directed lifecycle scenarios plus random reset traffic checked against a behavioural model.
module tb_n64_reset_handler;
    localparam int FC = 4;
    localparam int RD = 16;
    localparam int CW = 2;
    localparam int M_HARD = 0, M_BOOT = 1, M_RUN = 2, M_NMI = 3, M_DRAIN = 4;
    logic clk = 1'b0;
    logic reset;
    int passes = 0, fails = 0, total = 0;
    int m_fh, m_fs, m_rh, m_rs, m_mode, m_boot, m_cnt;
    logic m_sf, m_hf, m_irq;
    always #5 clk = ~clk;
    n64_reset_handler_if #(.COUNT_WIDTH(CW)) bus ();
    n64_reset_handler #(.FILTER_CYCLES(FC), .RELEASE_DELAY(RD), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_fh = 1; m_fs = 0; m_rh = 0; m_rs = 0;
        m_mode = M_HARD; m_boot = 0; m_cnt = 0;
        m_sf = 0; m_hf = 0; m_irq = 0;
    endtask
    // Decisions use the filtered levels as they stood before this edge.
    task automatic model_step();
        int ofh, ofs, h, s;
        bit es, eh;
        ofh = m_fh; ofs = m_fs; es = 0; eh = 0;
        h = int'(bus.n64_hard_reset); s = int'(bus.n64_soft_reset);
        if (h != m_fh) begin m_rh++; if (m_rh == FC) begin m_fh = h; m_rh = 0; end end else m_rh = 0;
        if (s != m_fs) begin m_rs++; if (m_rs == FC) begin m_fs = s; m_rs = 0; end end else m_rs = 0;
        if (m_mode == M_HARD) begin
            if (ofh == 0) begin m_mode = M_BOOT; m_boot = 0; end
        end else if (m_mode == M_BOOT) begin
            if (ofh == 1) m_mode = M_HARD;
            else if (m_boot == RD - 1) m_mode = M_RUN;
            else m_boot++;
        end else if (m_mode == M_RUN) begin
            if (ofh == 1) m_mode = M_DRAIN;
            else if (ofs == 1) begin m_mode = M_NMI; es = 1; end
        end else if (m_mode == M_NMI) begin
            if (ofh == 1) m_mode = M_DRAIN;
            else if (ofs == 0) m_mode = M_RUN;
        end else if (bus.drain_ack) begin
            m_mode = M_HARD; eh = 1;
        end
        m_sf = es ? 1'b1 : bus.flags_clear[0] ? 1'b0 : m_sf;
        m_hf = eh ? 1'b1 : bus.flags_clear[1] ? 1'b0 : m_hf;
        m_irq = es | eh;
        m_cnt = (m_cnt + int'(es)) % (1 << CW);
    endtask
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        check("drain_req", 32'(bus.drain_req), 32'(m_mode == M_DRAIN));
        check("n64_active", 32'(bus.n64_active), 32'(m_mode == M_RUN || m_mode == M_NMI));
        check("soft_flag", 32'(bus.soft_flag), 32'(m_sf));
        check("hard_flag", 32'(bus.hard_flag), 32'(m_hf));
        check("irq", 32'(bus.irq), 32'(m_irq));
        check("nmi_count", 32'(bus.nmi_count), 32'(m_cnt));
    endtask
    task automatic run_until_active(output int n);
        n = 0;
        while (bus.n64_active !== 1'b1 && n < 200) begin tick(); n++; end
        check("reach_active", 32'(bus.n64_active), 32'd1);
    endtask
    initial begin
        int n, hold;
        reset = 1'b1;
        bus.n64_hard_reset = 1'b1; bus.n64_soft_reset = 1'b0;
        bus.drain_ack = 1'b0; bus.flags_clear = 2'b00;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        check("rst_drain_req", 32'(bus.drain_req), 32'd0);
        check("rst_active", 32'(bus.n64_active), 32'd0);
        check("rst_flags", 32'({bus.soft_flag, bus.hard_flag, bus.irq}), 32'd0);
        check("rst_count", 32'(bus.nmi_count), 32'd0);
        repeat (4) tick();
        // Power-up: filter + BOOT entry + release delay.
        bus.n64_hard_reset = 1'b0;
        run_until_active(n);
        check("powerup_edges", 32'(n), 32'(FC + RD + 1));
        // Glitch rejection then a real NMI.
        bus.n64_soft_reset = 1'b1; repeat (3) tick();
        bus.n64_soft_reset = 1'b0; repeat (5) tick();
        check("glitch_count", 32'(bus.nmi_count), 32'd0);
        check("glitch_active", 32'(bus.n64_active), 32'd1);
        bus.n64_soft_reset = 1'b1; repeat (4) tick();
        check("nmi_not_yet", 32'(bus.soft_flag), 32'd0);
        tick();
        check("nmi_irq", 32'(bus.irq), 32'd1);
        check("nmi_flag", 32'(bus.soft_flag), 32'd1);
        check("nmi_count1", 32'(bus.nmi_count), 32'd1);
        tick();
        check("nmi_irq_drop", 32'(bus.irq), 32'd0);
        // Drain from NMI with a long-delayed ack.
        bus.n64_hard_reset = 1'b1; repeat (5) tick();
        check("drain_enter", 32'(bus.drain_req), 32'd1);
        repeat (50) tick();
        check("drain_hold", 32'(bus.drain_req), 32'd1);
        bus.drain_ack = 1'b1; tick(); bus.drain_ack = 1'b0;
        check("drain_exit_req", 32'(bus.drain_req), 32'd0);
        check("drain_exit_hflag", 32'(bus.hard_flag), 32'd1);
        check("drain_exit_irq", 32'(bus.irq), 32'd1);
        check("drain_exit_active", 32'(bus.n64_active), 32'd0);
        tick();
        check("drain_irq_drop", 32'(bus.irq), 32'd0);
        // Simultaneous hard+soft, then clear racing a set.
        bus.n64_hard_reset = 1'b0; bus.n64_soft_reset = 1'b0;
        run_until_active(n);
        bus.n64_hard_reset = 1'b1; bus.n64_soft_reset = 1'b1; repeat (5) tick();
        check("simul_drain", 32'(bus.drain_req), 32'd1);
        check("simul_count", 32'(bus.nmi_count), 32'd1);
        bus.flags_clear = 2'b10; tick(); bus.flags_clear = 2'b00;
        check("clear_hard", 32'(bus.hard_flag), 32'd0);
        bus.drain_ack = 1'b1; bus.flags_clear = 2'b11; tick();
        bus.drain_ack = 1'b0; bus.flags_clear = 2'b00;
        check("set_wins_hard", 32'(bus.hard_flag), 32'd1);
        check("clear_soft", 32'(bus.soft_flag), 32'd0);
        // Counter wrap at COUNT_WIDTH=2.
        bus.n64_hard_reset = 1'b0; bus.n64_soft_reset = 1'b0;
        run_until_active(n);
        for (int i = 0; i < 5; i++) begin
            bus.n64_soft_reset = 1'b1; repeat (5) tick();
            bus.n64_soft_reset = 1'b0; repeat (5) tick();
        end
        check("wrap_count", 32'(bus.nmi_count), 32'd2);
        // Boot aborted by hard reset: no flags.
        bus.flags_clear = 2'b11; tick(); bus.flags_clear = 2'b00;
        bus.n64_hard_reset = 1'b1; repeat (5) tick();
        bus.drain_ack = 1'b1; tick(); bus.drain_ack = 1'b0;
        bus.flags_clear = 2'b11; tick(); bus.flags_clear = 2'b00;
        bus.n64_hard_reset = 1'b0; repeat (10) tick();
        bus.n64_hard_reset = 1'b1; repeat (25) tick();
        check("abort_active", 32'(bus.n64_active), 32'd0);
        check("abort_flags", 32'({bus.soft_flag, bus.hard_flag, bus.drain_req}), 32'd0);
        // Async reset during DRAIN.
        bus.n64_hard_reset = 1'b0;
        run_until_active(n);
        bus.n64_hard_reset = 1'b1; repeat (5) tick();
        check("pre_async_drain", 32'(bus.drain_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_drain_req", 32'(bus.drain_req), 32'd0);
        check("async_count", 32'(bus.nmi_count), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        // Random traffic.
        for (int seg = 0; seg < 30; seg++) begin
            bus.n64_hard_reset = ($urandom % 3) == 0;
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                if ($urandom % 5 == 0) bus.n64_soft_reset = ~bus.n64_soft_reset;
                bus.drain_ack = ($urandom % 8) == 0;
                bus.flags_clear = ($urandom % 12 == 0) ? 2'($urandom) : 2'b00;
                tick();
            end
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
